// File: rtl/disp_mux_alarma.sv
// Two-digit multiplexed 7-segment driver for the alarm FSM codes (estado on digit0, alerta on digit1).
// Scans with anti-ghost blanking and optional blink on digit1. Inputs are latched once per frame.
module disp_mux_alarma #(
   parameter int REFRESH_DIV = 50000,
   parameter int BLANK_CYC   = 500,
   parameter int BLINK_DIV   = 12500000
) (
   input  logic       CLK_clk_i,
   input  logic       RST_rst_i,
   input  logic [6:0] estado_seg_i,
   input  logic [6:0] alerta_seg_i,
   input  logic       blink_en_i,
   output logic [6:0] seg_o,
   output logic [3:0] an_o
);

   localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   localparam logic [CNT_W-1:0]   BLANK_LAST   = CNT_W'(BLANK_CYC - 1);
   localparam logic [CNT_W-1:0]   REFRESH_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [BLINK_W-1:0] BLINK_LAST   = BLINK_W'(BLINK_DIV - 1);

   localparam logic [6:0] SEG_OFF = 7'h7F;
   localparam logic [3:0] AN_OFF  = 4'hF;

   typedef enum logic [1:0] {
      S_BLANK0 = 2'd0,
      S_DIG0   = 2'd1,
      S_BLANK1 = 2'd2,
      S_DIG1   = 2'd3
   } scan_state_t;

   scan_state_t        state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [BLINK_W-1:0] blink_cnt_q;
   logic               blink_ph_q;
   logic [6:0]         est_q, ale_q;
   logic               blink_q;
   logic [6:0]         seg_d;
   logic [3:0]         an_d;
   logic               snap;

   // Frame start is the first cycle of S_BLANK0; both digits are latched together there
   assign snap = (state_q == S_BLANK0) && (cnt_q == '0);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_W'(1);
      seg_d   = SEG_OFF;
      an_d    = AN_OFF;
      case (state_q)
         S_BLANK0: begin
            if (cnt_q == BLANK_LAST) begin
               state_d = S_DIG0;
               cnt_d   = '0;
            end
         end
         S_DIG0: begin
            seg_d = est_q;
            an_d  = 4'b1110;
            if (cnt_q == REFRESH_LAST) begin
               state_d = S_BLANK1;
               cnt_d   = '0;
            end
         end
         S_BLANK1: begin
            if (cnt_q == BLANK_LAST) begin
               state_d = S_DIG1;
               cnt_d   = '0;
            end
         end
         S_DIG1: begin
            // Blink only blanks the segments; the anode keeps its slot so scan timing is unchanged
            seg_d = (blink_q && blink_ph_q) ? SEG_OFF : ale_q;
            an_d  = 4'b1101;
            if (cnt_q == REFRESH_LAST) begin
               state_d = S_BLANK0;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = S_BLANK0;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge CLK_clk_i) begin
      if (RST_rst_i) begin
         state_q     <= S_BLANK0;
         cnt_q       <= '0;
         blink_cnt_q <= '0;
         blink_ph_q  <= 1'b0;
         est_q       <= SEG_OFF;
         ale_q       <= SEG_OFF;
         blink_q     <= 1'b0;
         seg_o       <= SEG_OFF;
         an_o        <= AN_OFF;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         seg_o   <= seg_d;
         an_o    <= an_d;
         if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_q <= '0;
            blink_ph_q  <= ~blink_ph_q;
         end else begin
            blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
         end
         if (snap) begin
            est_q   <= estado_seg_i;
            ale_q   <= alerta_seg_i;
            blink_q <= blink_en_i;
         end
      end
   end

endmodule

// File: tb/tb_disp_mux_alarma.sv
// Self-checking bench for disp_mux_alarma: a frame-position model predicts each registered output
// when stimulus is applied; predictions are queued and compared on the following falling edge.
module tb_disp_mux_alarma;

   localparam int REFRESH_DIV = 4;
   localparam int BLANK_CYC   = 1;
   localparam int BLINK_DIV   = 16;
   localparam int FRAME       = 2 * (BLANK_CYC + REFRESH_DIV);

   logic       CLK_clk_i;
   logic       RST_rst_i;
   logic [6:0] estado_seg_i;
   logic [6:0] alerta_seg_i;
   logic       blink_en_i;
   logic [6:0] seg_o;
   logic [3:0] an_o;

   typedef struct {
      logic [6:0] seg;
      logic [3:0] an;
   } expect_t;

   expect_t    scoreboard[$];
   int         checkCount;
   int         failCount;
   string      phase;

   int         mPos;
   int         mBlinkCnt;
   logic [6:0] mEst;
   logic [6:0] mAle;
   logic       mBlk;

   disp_mux_alarma #(
      .REFRESH_DIV(REFRESH_DIV),
      .BLANK_CYC  (BLANK_CYC),
      .BLINK_DIV  (BLINK_DIV)
   ) dut (
      .CLK_clk_i   (CLK_clk_i),
      .RST_rst_i   (RST_rst_i),
      .estado_seg_i(estado_seg_i),
      .alerta_seg_i(alerta_seg_i),
      .blink_en_i  (blink_en_i),
      .seg_o       (seg_o),
      .an_o        (an_o)
   );

   initial CLK_clk_i = 1'b0;
   always #5 CLK_clk_i = ~CLK_clk_i;

   task automatic checkOutput(input string tag, input logic [6:0] observed, input logic [6:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %b, expected %b (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   // Predicts the output register value produced by the coming edge, then advances the model
   function automatic expect_t predict();
      expect_t e;
      logic    ph;
      e.seg = 7'h7F;
      e.an  = 4'hF;
      if (RST_rst_i) begin
         mPos      = 0;
         mBlinkCnt = 0;
         mEst      = 7'h7F;
         mAle      = 7'h7F;
         mBlk      = 1'b0;
      end else begin
         ph = ((mBlinkCnt / BLINK_DIV) % 2) == 1;
         if (mPos < BLANK_CYC) begin
            e.seg = 7'h7F;
         end else if (mPos < BLANK_CYC + REFRESH_DIV) begin
            e.seg = mEst;
            e.an  = 4'b1110;
         end else if (mPos < 2 * BLANK_CYC + REFRESH_DIV) begin
            e.seg = 7'h7F;
         end else begin
            e.seg = (mBlk && ph) ? 7'h7F : mAle;
            e.an  = 4'b1101;
         end
         if (mPos == 0) begin
            mEst = estado_seg_i;
            mAle = alerta_seg_i;
            mBlk = blink_en_i;
         end
         mPos = (mPos + 1) % FRAME;
         mBlinkCnt++;
      end
      return e;
   endfunction

   task automatic applyStimulus(input int cycles);
      expect_t e;
      for (int i = 0; i < cycles; i++) begin
         scoreboard.push_back(predict());
         @(posedge CLK_clk_i);
         @(negedge CLK_clk_i);
         e = scoreboard.pop_front();
         checkOutput({phase, " seg"}, seg_o, e.seg);
         checkOutput({phase, " an"}, {3'b000, an_o}, {3'b000, e.an});
      end
   endtask

   task automatic runToPos(input int target);
      int guard;
      guard = 0;
      while (mPos != target && guard < 2 * FRAME) begin
         applyStimulus(1);
         guard++;
      end
      checkOutput({phase, " align"}, (mPos == target) ? 7'd1 : 7'd0, 7'd1);
   endtask

   initial begin
      logic [6:0] sweepEst[4];
      logic [6:0] sweepAle[4];
      checkCount = 0;
      failCount  = 0;
      mPos       = 0;
      mBlinkCnt  = 0;
      mEst       = 7'h7F;
      mAle       = 7'h7F;
      mBlk       = 1'b0;

      @(negedge CLK_clk_i);
      phase        = "reset";
      RST_rst_i    = 1'b1;
      estado_seg_i = 7'b1111001;
      alerta_seg_i = 7'b0000111;
      blink_en_i   = 1'b0;
      applyStimulus(3);

      phase     = "frame";
      RST_rst_i = 1'b0;
      applyStimulus(3 * FRAME);

      phase = "snapshot";
      runToPos(2);
      estado_seg_i = 7'b0100100;
      applyStimulus(2 * FRAME);

      phase        = "blink";
      blink_en_i   = 1'b1;
      alerta_seg_i = 7'b0001000;
      applyStimulus(8 * FRAME);
      blink_en_i = 1'b0;

      phase        = "midreset";
      estado_seg_i = 7'b1111001;
      alerta_seg_i = 7'b0000111;
      runToPos(2 * BLANK_CYC + REFRESH_DIV + 1);
      RST_rst_i = 1'b1;
      applyStimulus(1);
      RST_rst_i = 1'b0;
      applyStimulus(2 * FRAME);

      phase       = "sweep";
      sweepEst[0] = 7'b1000000; sweepAle[0] = 7'b1000000;
      sweepEst[1] = 7'b1111001; sweepAle[1] = 7'b0000111;
      sweepEst[2] = 7'b0100100; sweepAle[2] = 7'b0001011;
      sweepEst[3] = 7'b0110000; sweepAle[3] = 7'b0001000;
      for (int k = 0; k < 4; k++) begin
         estado_seg_i = sweepEst[k];
         alerta_seg_i = sweepAle[k];
         applyStimulus(2 * FRAME);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
